// File: rtl/video_pattern_source_pkg.sv
// Shared definitions for the video pattern source: FSM encoding, pattern
// selectors and the colour-bar palette.
package video_pattern_source_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [1:0] PAT_BARS    = 2'd0;
   localparam logic [1:0] PAT_RAMP    = 2'd1;
   localparam logic [1:0] PAT_CHECKER = 2'd2;
   localparam logic [1:0] PAT_SOLID   = 2'd3;

   localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
   localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
   localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
   localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
   localparam logic [23:0] BAR_RED     = 24'hFF0000;
   localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
   localparam logic [23:0] BAR_BLACK   = 24'h000000;

   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    bar_colour = BAR_WHITE;
         3'd1:    bar_colour = BAR_YELLOW;
         3'd2:    bar_colour = BAR_CYAN;
         3'd3:    bar_colour = BAR_GREEN;
         3'd4:    bar_colour = BAR_MAGENTA;
         3'd5:    bar_colour = BAR_RED;
         3'd6:    bar_colour = BAR_BLUE;
         default: bar_colour = BAR_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/video_pattern_source_pattern_gen.sv
// Pixel generator: maps pattern, column and line parity onto a registered
// RGB888 value that updates only on clken slots.
module vps_pattern_gen
   import video_pattern_source_pkg::*;
#(
   parameter logic [10:0] IMG_HDISP = 11'd640
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        clear,
   input  logic        active,
   input  logic [1:0]  pattern,
   input  logic [10:0] hcnt,
   input  logic        line_b5,
   input  logic [23:0] solid,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue
);

   localparam logic [10:0] BAR_W = (IMG_HDISP < 11'd8) ? 11'd1 : (IMG_HDISP >> 3);

   logic [10:0] bar_idx;
   logic [23:0] pix;
   logic [23:0] rgb_d;
   logic [23:0] rgb_q;

   always_comb begin
      bar_idx = hcnt / BAR_W;
      pix     = 24'h0;
      case (pattern)
         PAT_BARS:    pix = bar_colour((bar_idx > 11'd7) ? 3'd7 : bar_idx[2:0]);
         PAT_RAMP:    pix = {3{hcnt[7:0]}};
         PAT_CHECKER: pix = (hcnt[5] ^ line_b5) ? 24'hFFFFFF : 24'h000000;
         default:     pix = solid;
      endcase

      rgb_d = rgb_q;
      if (clear) begin
         rgb_d = 24'h0;
      end else if (load) begin
         rgb_d = active ? pix : 24'h0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_q <= 24'h0;
      end else begin
         rgb_q <= rgb_d;
      end
   end

   assign red   = rgb_q[23:16];
   assign green = rgb_q[15:8];
   assign blue  = rgb_q[7:0];

endmodule

// File: rtl/video_pattern_source.sv
// Test-pattern video source: slot divider, raster counters and run/drain FSM
// that only ever stops on a frame boundary.
module video_pattern_source
   import video_pattern_source_pkg::*;
#(
   parameter logic [10:0] IMG_HDISP = 11'd640,
   parameter logic [10:0] IMG_VDISP = 11'd480,
   parameter logic [10:0] H_BLANK   = 11'd160,
   parameter logic [10:0] V_BLANK   = 11'd45,
   parameter logic [3:0]  CLKEN_DIV = 4'd1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   input  logic [23:0] cfg_solid_rgb,
   output logic        post_frame_vsync,
   output logic        post_frame_href,
   output logic        post_frame_clken,
   output logic [7:0]  post_img_red,
   output logic [7:0]  post_img_green,
   output logic [7:0]  post_img_blue,
   output logic [15:0] frame_cnt,
   output logic        busy
);

   localparam logic [10:0] H_MAX   = IMG_HDISP + H_BLANK - 11'd1;
   localparam logic [10:0] V_MAX   = IMG_VDISP + V_BLANK - 11'd1;
   localparam logic [3:0]  DIV_MAX = CLKEN_DIV - 4'd1;

   logic [1:0]  state_q, state_d;
   logic [3:0]  div_q, div_d;
   logic [10:0] hcnt_q, hcnt_d;
   logic [10:0] vcnt_q, vcnt_d;
   logic        vsync_q, vsync_d;
   logic        href_q, href_d;
   logic        clken_q, clken_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [1:0]  pattern_q, pattern_d;
   logic [23:0] solid_q, solid_d;

   logic        slot, frame_end, sample, go_idle;
   logic        vsync_now, href_now, line_b5;
   logic [1:0]  pat_use;
   logic [23:0] solid_use;

   always_comb begin
      slot      = (state_q != ST_IDLE) && (div_q == 4'd0);
      frame_end = slot && (hcnt_q == H_MAX) && (vcnt_q == V_MAX);
      sample    = slot && (hcnt_q == 11'd0) && (vcnt_q == 11'd0);
      vsync_now = (vcnt_q >= V_BLANK);
      href_now  = vsync_now && (hcnt_q < IMG_HDISP);
      pat_use   = sample ? pattern_sel : pattern_q;
      solid_use = sample ? cfg_solid_rgb : solid_q;
      // Bit 5 of (vcnt - V_BLANK): operand bits plus the borrow out of bits 4:0.
      line_b5   = vcnt_q[5] ^ V_BLANK[5] ^ (vcnt_q[4:0] < V_BLANK[4:0]);

      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (enable) state_d = ST_RUN;
         ST_RUN:   if (!enable) state_d = frame_end ? ST_IDLE : ST_DRAIN;
         ST_DRAIN: begin
            if (enable)         state_d = ST_RUN;
            else if (frame_end) state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
      go_idle = (state_q != ST_IDLE) && (state_d == ST_IDLE);

      div_d       = div_q;
      hcnt_d      = hcnt_q;
      vcnt_d      = vcnt_q;
      vsync_d     = vsync_q;
      href_d      = href_q;
      clken_d     = clken_q;
      pattern_d   = pattern_q;
      solid_d     = solid_q;
      frame_cnt_d = frame_end ? frame_cnt_q + 16'd1 : frame_cnt_q;

      if (go_idle) begin
         div_d   = 4'd0;
         hcnt_d  = 11'd0;
         vcnt_d  = 11'd0;
         vsync_d = 1'b0;
         href_d  = 1'b0;
         clken_d = 1'b0;
      end else if (state_q != ST_IDLE) begin
         div_d   = (div_q == DIV_MAX) ? 4'd0 : div_q + 4'd1;
         clken_d = slot;
         if (slot) begin
            vsync_d   = vsync_now;
            href_d    = href_now;
            pattern_d = pat_use;
            solid_d   = solid_use;
            if (hcnt_q == H_MAX) begin
               hcnt_d = 11'd0;
               vcnt_d = (vcnt_q == V_MAX) ? 11'd0 : vcnt_q + 11'd1;
            end else begin
               hcnt_d = hcnt_q + 11'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         div_q       <= 4'd0;
         hcnt_q      <= 11'd0;
         vcnt_q      <= 11'd0;
         vsync_q     <= 1'b0;
         href_q      <= 1'b0;
         clken_q     <= 1'b0;
         frame_cnt_q <= 16'd0;
         pattern_q   <= 2'd0;
         solid_q     <= 24'h0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         vsync_q     <= vsync_d;
         href_q      <= href_d;
         clken_q     <= clken_d;
         frame_cnt_q <= frame_cnt_d;
         pattern_q   <= pattern_d;
         solid_q     <= solid_d;
      end
   end

   vps_pattern_gen #(
      .IMG_HDISP (IMG_HDISP)
   ) u_pattern_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (slot),
      .clear   (go_idle),
      .active  (href_now),
      .pattern (pat_use),
      .hcnt    (hcnt_q),
      .line_b5 (line_b5),
      .solid   (solid_use),
      .red     (post_img_red),
      .green   (post_img_green),
      .blue    (post_img_blue)
   );

   assign post_frame_vsync = vsync_q;
   assign post_frame_href  = href_q;
   assign post_frame_clken = clken_q;
   assign frame_cnt        = frame_cnt_q;
   assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_video_pattern_source.sv
// Directed bench for video_pattern_source on a 12x6 raster (8x4 active),
// with one instance at CLKEN_DIV=1 and one at CLKEN_DIV=3.
module tb_video_pattern_source;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, enable, enable3;
   logic [1:0]  pattern_sel;
   logic [23:0] cfg_solid_rgb;

   logic        vsync, href, clken, busy;
   logic [7:0]  red, green, blue;
   logic [15:0] frame_cnt;
   logic        vsync3, href3, clken3, busy3;
   logic [7:0]  red3, green3, blue3;
   logic [15:0] frame_cnt3;

   logic [23:0] rgb1, rgb3;
   logic [26:0] vid1, vid3;
   assign rgb1 = {red, green, blue};
   assign rgb3 = {red3, green3, blue3};
   assign vid1 = {vsync, href, clken, rgb1};
   assign vid3 = {vsync3, href3, clken3, rgb3};

   int n_cmp = 0;
   int n_err = 0;

   logic [23:0] bars_exp [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   video_pattern_source #(
      .IMG_HDISP (11'd8), .IMG_VDISP (11'd4), .H_BLANK (11'd4), .V_BLANK (11'd2),
      .CLKEN_DIV (4'd1)
   ) dut (
      .clk (clk), .rst_n (rst_n), .enable (enable), .pattern_sel (pattern_sel),
      .cfg_solid_rgb (cfg_solid_rgb), .post_frame_vsync (vsync), .post_frame_href (href),
      .post_frame_clken (clken), .post_img_red (red), .post_img_green (green),
      .post_img_blue (blue), .frame_cnt (frame_cnt), .busy (busy)
   );

   video_pattern_source #(
      .IMG_HDISP (11'd8), .IMG_VDISP (11'd4), .H_BLANK (11'd4), .V_BLANK (11'd2),
      .CLKEN_DIV (4'd3)
   ) dut3 (
      .clk (clk), .rst_n (rst_n), .enable (enable3), .pattern_sel (pattern_sel),
      .cfg_solid_rgb (cfg_solid_rgb), .post_frame_vsync (vsync3), .post_frame_href (href3),
      .post_frame_clken (clken3), .post_img_red (red3), .post_img_green (green3),
      .post_img_blue (blue3), .frame_cnt (frame_cnt3), .busy (busy3)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int          clk_cnt, vs_cnt, hr_cnt, hr_pulses, pos, low_slots, waited;
      int          errs, run_len, ck_err, d_err;
      logic        hr_prev;
      logic [7:0]  px;
      logic [23:0] cap [8];

      rst_n = 1'b0; enable = 1'b0; enable3 = 1'b0;
      pattern_sel = 2'd0; cfg_solid_rgb = 24'h0;
      repeat (3) tick();
      chk("rst_vid", vid1, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fcnt", frame_cnt, 0);
      chk("rst_vid3", vid3, 0);
      chk("rst_busy3", busy3, 0);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", busy, 0);

      // One full frame of colour bars with enable held high
      pattern_sel = 2'd0;
      enable = 1'b1;
      tick();
      chk("start_busy", busy, 1);
      chk("start_clken", clken, 0);
      clk_cnt = 0; vs_cnt = 0; hr_cnt = 0; hr_pulses = 0; pos = 0; hr_prev = 1'b0;
      for (int i = 0; i < 72; i++) begin
         tick();
         clk_cnt += clken ? 1 : 0;
         vs_cnt  += vsync ? 1 : 0;
         hr_cnt  += href ? 1 : 0;
         if (href && !hr_prev) hr_pulses++;
         if (href && hr_pulses == 1 && pos < 8) begin
            cap[pos] = rgb1;
            pos++;
         end
         hr_prev = href;
         if (i == 70) chk("fcnt_before_end", frame_cnt, 0);
      end
      chk("frame_clken_slots", clk_cnt, 72);
      chk("frame_vsync_slots", vs_cnt, 48);
      chk("frame_href_pulses", hr_pulses, 4);
      chk("frame_href_cycles", hr_cnt, 32);
      chk("frame_cnt_one", frame_cnt, 1);
      for (int k = 0; k < 8; k++) chk($sformatf("bar%0d", k), cap[k], bars_exp[k]);

      // Reset pulse in the middle of an active line of the second frame
      repeat (30) tick();
      chk("pre_rst_href", href, 1);
      pattern_sel = 2'd3;
      cfg_solid_rgb = 24'h123456;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_vid", vid1, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_fcnt", frame_cnt, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("restart_busy", busy, 1);
      low_slots = 0; waited = 0;
      while (!vsync && waited < 200) begin
         tick();
         waited++;
         if (!vsync) low_slots += clken ? 1 : 0;
      end
      chk("vs_low_slots", low_slots, 24);
      chk("solid_px", rgb1, 24'h123456);

      // Pattern change mid-frame must not show until the next frame
      pattern_sel = 2'd1;
      errs = 0;
      for (int i = 0; i < 47; i++) begin
         tick();
         if (href && rgb1 !== 24'h123456) errs++;
         if (!href && rgb1 !== 24'h0) errs++;
      end
      chk("solid_hold_errs", errs, 0);
      chk("fcnt_after_restart", frame_cnt, 1);
      repeat (24) tick();
      for (int k = 0; k < 8; k++) begin
         tick();
         px = 8'(k);
         chk($sformatf("ramp%0d", k), {href, rgb1}, {1'b1, px, px, px});
      end

      // Enable dropped during line 1: frame completes, then idle
      enable = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("drain_idle_before", busy, 0);
      pattern_sel = 2'd0;
      enable = 1'b1;
      tick();
      hr_cnt = 0;
      for (int i = 0; i < 72; i++) begin
         tick();
         hr_cnt += href ? 1 : 0;
         if (i == 14) enable = 1'b0;
         if (i == 70) chk("drain_busy_last", busy, 1);
      end
      chk("drain_busy_fall", busy, 0);
      chk("drain_vid_zero", vid1, 0);
      chk("drain_fcnt", frame_cnt, 1);
      chk("drain_href_cycles", hr_cnt, 32);
      repeat (10) tick();
      chk("drain_stays_idle", {busy, clken, frame_cnt}, {2'b00, 16'd1});

      // CLKEN_DIV=3 instance with the gray ramp
      pattern_sel = 2'd1;
      enable3 = 1'b1;
      tick();
      clk_cnt = 0; ck_err = 0; d_err = 0; run_len = 0; hr_pulses = 0; hr_prev = 1'b0;
      for (int i = 0; i < 216; i++) begin
         tick();
         clk_cnt += clken3 ? 1 : 0;
         if (clken3 !== (i % 3 == 0)) ck_err++;
         if (href3 && !hr_prev) hr_pulses++;
         if (href3 && hr_pulses == 1) begin
            px = 8'(run_len / 3);
            if (rgb3 !== {px, px, px}) d_err++;
            run_len++;
         end
         hr_prev = href3;
         if (i == 212) chk("div3_fcnt_before", frame_cnt3, 0);
         if (i == 213) chk("div3_fcnt_after", frame_cnt3, 1);
      end
      chk("div3_clken_cnt", clk_cnt, 72);
      chk("div3_clken_phase", ck_err, 0);
      chk("div3_href_len", run_len, 24);
      chk("div3_hold_errs", d_err, 0);
      enable3 = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
